// File: rtl/scoreboard_tx_sched.sv
// Scoreboard frame scheduler: arbitrates score/time requests and streams a
// 5-byte frame (HDR, TYPE, D0, D1, CSUM) to a UART transmitter.
module scoreboard_tx_sched #(
  parameter logic [7:0]  HDR          = 8'hA5,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       score_req,
  input  logic [7:0] home_score,
  input  logic [7:0] guest_score,
  input  logic       time_req,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       score_ack,
  output logic       time_ack,
  output logic       frame_busy,
  output logic       err_timeout
);

  localparam int unsigned CNT_W      = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned IDX_W      = 3;
  localparam logic [7:0]  TYPE_SCORE = 8'h01;
  localparam logic [7:0]  TYPE_TIME  = 8'h02;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(4);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             last_time_q, last_time_n;
  logic [7:0]       type_q, type_n, d0_q, d0_n, d1_q, d1_n;
  logic [7:0]       tx_data_n;
  logic             tx_start_n, score_ack_n, time_ack_n, frame_busy_n, err_timeout_n;
  logic             busy_c, grant_time_c;

  // Anything other than a clean 1 (including X) is treated as idle.
  always_comb begin
    busy_c = 1'b0;
    if (tx_busy == 1'b1) busy_c = 1'b1;
  end

  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                            input logic [7:0] t,
                                            input logic [7:0] d0,
                                            input logic [7:0] d1);
    case (idx)
      IDX_W'(0): frame_byte = HDR;
      IDX_W'(1): frame_byte = t;
      IDX_W'(2): frame_byte = d0;
      IDX_W'(3): frame_byte = d1;
      IDX_W'(4): frame_byte = t ^ d0 ^ d1;
      default:   frame_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      last_time_q <= 1'b1;
      type_q      <= 8'h00;
      d0_q        <= 8'h00;
      d1_q        <= 8'h00;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      score_ack   <= 1'b0;
      time_ack    <= 1'b0;
      frame_busy  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_n;
      idx_q       <= idx_n;
      cnt_q       <= cnt_n;
      last_time_q <= last_time_n;
      type_q      <= type_n;
      d0_q        <= d0_n;
      d1_q        <= d1_n;
      tx_data     <= tx_data_n;
      tx_start    <= tx_start_n;
      score_ack   <= score_ack_n;
      time_ack    <= time_ack_n;
      frame_busy  <= frame_busy_n;
      err_timeout <= err_timeout_n;
    end
  end

  always_comb begin
    state_n       = state_q;
    idx_n         = idx_q;
    cnt_n         = cnt_q;
    last_time_n   = last_time_q;
    type_n        = type_q;
    d0_n          = d0_q;
    d1_n          = d1_q;
    tx_data_n     = tx_data;
    tx_start_n    = 1'b0;
    score_ack_n   = 1'b0;
    time_ack_n    = 1'b0;
    frame_busy_n  = frame_busy;
    err_timeout_n = 1'b0;
    // On a tie, time wins only if score was granted last.
    grant_time_c  = time_req && (!score_req || !last_time_q);

    case (state_q)
      IDLE: begin
        if (score_req || time_req) begin
          type_n       = grant_time_c ? TYPE_TIME : TYPE_SCORE;
          d0_n         = grant_time_c ? minutes : home_score;
          d1_n         = grant_time_c ? seconds : guest_score;
          last_time_n  = grant_time_c;
          score_ack_n  = !grant_time_c;
          time_ack_n   = grant_time_c;
          frame_busy_n = 1'b1;
          tx_data_n    = HDR;
          idx_n        = '0;
          state_n      = LOAD;
        end
      end
      LOAD: begin
        tx_start_n = 1'b1;
        state_n    = START;
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_c) begin
          state_n = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          err_timeout_n = 1'b1;
          frame_busy_n  = 1'b0;
          cnt_n         = '0;
          idx_n         = '0;
          state_n       = IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!busy_c) begin
          if (idx_q < LAST_IDX) begin
            idx_n      = idx_q + IDX_W'(1);
            tx_data_n  = frame_byte(idx_q + IDX_W'(1), type_q, d0_q, d1_q);
            tx_start_n = 1'b1;
            state_n    = START;
          end else begin
            idx_n        = '0;
            frame_busy_n = 1'b0;
            state_n      = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
